// File: rtl/bus_arbiter_split_if.sv
// Bus interface between the requesting masters / slaves and the arbiter.
// master modport : the agent side (drives requests, done, split, observes grants)
// slave modport  : the arbiter side (observes requests, drives grants/status)
interface bus_arbiter_split_if #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int SLAVE_LEN   = 2
);
   localparam int OW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0]           request;
   logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel;
   logic                             trans_done;
   logic [NUM_SLAVES-1:0]            split_en;
   logic [NUM_MASTERS-1:0]           grant;
   logic                             arbiter_busy;
   logic                             bus_busy;
   logic [OW-1:0]                    owner;
   logic [SLAVE_LEN-1:0]             owner_slave;
   logic [NUM_MASTERS-1:0]           split_pending;
   logic                             timeout;

   modport master (
      output request, slave_sel, trans_done, split_en,
      input  grant, arbiter_busy, bus_busy, owner, owner_slave, split_pending, timeout
   );

   modport slave (
      input  request, slave_sel, trans_done, split_en,
      output grant, arbiter_busy, bus_busy, owner, owner_slave, split_pending, timeout
   );
endinterface

// File: rtl/bus_arbiter_split.sv
// N-master bus arbiter with slave-select routing, split parking and a
// bus-hold timeout.
// Ports:
//   i_clk   : bus clock
//   i_reset : synchronous active-high reset
//   io_bus  : arbiter side of bus_arbiter_split_if (requests, slave selects,
//             trans_done, split_en in; grant, busy flags, owner, owner_slave,
//             split_pending, timeout out)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | bus free, waiting for an eligible request
// S_ARB  | choose winner, latch owner/owner_slave, grant on exit
// S_BUSY | owner holds the bus until done, split, abort or timeout
module bus_arbiter_split #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int SLAVE_LEN   = 2,
   parameter int RR_MODE     = 0,
   parameter int MAX_COUNT   = 500
) (
   input logic                 i_clk,
   input logic                 i_reset,
   bus_arbiter_split_if.slave  io_bus
);
   localparam int OW = $clog2(NUM_MASTERS);
   localparam int CW = $clog2(MAX_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_BUSY} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] r_split_pending;
   logic [NUM_MASTERS-1:0] r_resumed;
   logic [SLAVE_LEN-1:0]   r_park_slave [NUM_MASTERS];
   logic [OW-1:0]          r_owner;
   logic [OW-1:0]          r_rr_ptr;
   logic [SLAVE_LEN-1:0]   r_owner_slave;
   logic [CW-1:0]          r_cnt;

   logic [SLAVE_LEN-1:0]   w_sel [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] w_elig;
   logic [NUM_MASTERS-1:0] w_release;
   logic                   w_res_vld;
   logic                   w_win_vld;
   logic [OW-1:0]          w_win;
   int                     w_best;
   int                     w_dist;
   logic                   w_own_split;
   logic                   w_go_busy;
   logic                   w_do_done;
   logic                   w_do_split;
   logic                   w_do_abort;
   logic                   w_do_timeout;

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_sel[i] = io_bus.slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
      end
   end

   // A master is blocked while parked, while targeting a slave outside the
   // populated range, or while targeting a slave some other master is parked on.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_elig[i] = io_bus.request[i] & ~r_split_pending[i] &
                     ({1'b0, w_sel[i]} < (SLAVE_LEN+1)'(NUM_SLAVES));
         for (int k = 0; k < NUM_MASTERS; k++) begin
            if (k != i && r_split_pending[k] && r_park_slave[k] == w_sel[i]) begin
               w_elig[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_release = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         for (int j = 0; j < NUM_SLAVES; j++) begin
            if (r_split_pending[i] && r_park_slave[i] == SLAVE_LEN'(j) &&
                !io_bus.split_en[j]) begin
               w_release[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_own_split = 1'b0;
      for (int j = 0; j < NUM_SLAVES; j++) begin
         if (r_owner_slave == SLAVE_LEN'(j) && io_bus.split_en[j]) begin
            w_own_split = 1'b1;
         end
      end
   end

   // Resumed masters first (lowest index); otherwise the smallest distance
   // from the rotation origin, which is index 0 in fixed-priority mode.
   always_comb begin
      w_res_vld = 1'b0;
      w_win_vld = 1'b0;
      w_win     = '0;
      w_best    = NUM_MASTERS;
      w_dist    = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_elig[i] && r_resumed[i] && !w_res_vld) begin
            w_res_vld = 1'b1;
            w_win     = OW'(i);
         end
      end
      if (w_res_vld) begin
         w_win_vld = 1'b1;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            w_dist = (RR_MODE != 0) ?
                     ((i - int'(r_rr_ptr) + NUM_MASTERS) % NUM_MASTERS) : i;
            if (w_elig[i] && w_dist < w_best) begin
               w_best = w_dist;
               w_win  = OW'(i);
            end
         end
         w_win_vld = (w_best < NUM_MASTERS);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_go_busy    = 1'b0;
      w_do_done    = 1'b0;
      w_do_split   = 1'b0;
      w_do_abort   = 1'b0;
      w_do_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_elig) w_state_nxt = S_ARB;
         end
         S_ARB: begin
            if (w_win_vld) begin
               w_state_nxt = S_BUSY;
               w_go_busy   = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            // Exit causes are mutually exclusive, highest priority first.
            if (i_reset) begin
               w_state_nxt = S_IDLE;
            end else if (io_bus.trans_done) begin
               w_state_nxt = S_IDLE;
               w_do_done   = 1'b1;
            end else if (w_own_split) begin
               w_state_nxt = S_IDLE;
               w_do_split  = 1'b1;
            end else if (!io_bus.request[r_owner]) begin
               w_state_nxt = S_IDLE;
               w_do_abort  = 1'b1;
            end else if (r_cnt == CW'(MAX_COUNT - 1)) begin
               w_state_nxt  = S_IDLE;
               w_do_timeout = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_grant         <= '0;
         r_split_pending <= '0;
         r_resumed       <= '0;
         r_owner         <= '0;
         r_rr_ptr        <= '0;
         r_owner_slave   <= '0;
         r_cnt           <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            r_park_slave[i] <= '0;
         end
      end else begin
         r_state         <= w_state_nxt;
         r_split_pending <= r_split_pending & ~w_release;
         r_resumed       <= r_resumed | w_release;
         if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_go_busy) begin
            r_owner          <= w_win;
            r_owner_slave    <= w_sel[w_win];
            r_grant          <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
            r_cnt            <= '0;
            r_resumed[w_win] <= 1'b0;
         end
         if (w_do_done || w_do_split || w_do_abort || w_do_timeout) begin
            r_grant <= '0;
         end
         if (w_do_done && RR_MODE != 0) begin
            r_rr_ptr <= (r_owner == OW'(NUM_MASTERS - 1)) ? '0 : r_owner + OW'(1);
         end
         if (w_do_split) begin
            r_split_pending[r_owner] <= 1'b1;
            r_park_slave[r_owner]    <= r_owner_slave;
         end
      end
   end

   assign io_bus.grant         = r_grant;
   assign io_bus.arbiter_busy  = (r_state != S_IDLE);
   assign io_bus.bus_busy      = (r_state == S_BUSY);
   assign io_bus.owner         = r_owner;
   assign io_bus.owner_slave   = r_owner_slave;
   assign io_bus.split_pending = r_split_pending;
   assign io_bus.timeout       = w_do_timeout;
endmodule

// File: tb/tb_bus_arbiter_split.sv
// Bench for bus_arbiter_split: a fixed-priority and a round-robin instance
// share one stimulus stream and are each compared to a behavioural model.
module tb_bus_arbiter_split;
   localparam int NM   = 4;
   localparam int NS   = 3;
   localparam int SL   = 2;
   localparam int MAXC = 10;
   localparam int P_IDLE = 0, P_ARB = 1, P_BUSY = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [NM-1:0]    req;
   logic [NM*SL-1:0] sel_bus;
   logic             td;
   logic [NS-1:0]    sen;
   int               sel_i [NM];

   int n_checks = 0;
   int n_errors = 0;

   always_comb begin
      sel_bus = '0;
      for (int i = 0; i < NM; i++) sel_bus[i*SL +: SL] = SL'(sel_i[i]);
   end

   bus_arbiter_split_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL)) bus_fp ();
   bus_arbiter_split_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL)) bus_rr ();

   assign bus_fp.request = req;  assign bus_rr.request = req;
   assign bus_fp.slave_sel = sel_bus;  assign bus_rr.slave_sel = sel_bus;
   assign bus_fp.trans_done = td;  assign bus_rr.trans_done = td;
   assign bus_fp.split_en = sen;  assign bus_rr.split_en = sen;

   bus_arbiter_split #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL),
                       .RR_MODE(0), .MAX_COUNT(MAXC))
      u_dut_fp (.i_clk(clk), .i_reset(rst), .io_bus(bus_fp.slave));
   bus_arbiter_split #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL),
                       .RR_MODE(1), .MAX_COUNT(MAXC))
      u_dut_rr (.i_clk(clk), .i_reset(rst), .io_bus(bus_rr.slave));

   logic [NM-1:0] d_grant [2];
   logic [NM-1:0] d_spend [2];
   logic          d_abusy [2];
   logic          d_bbusy [2];
   logic          d_tout  [2];
   logic [1:0]    d_owner [2];
   logic [SL-1:0] d_oslave[2];
   assign d_grant[0] = bus_fp.grant;          assign d_grant[1] = bus_rr.grant;
   assign d_spend[0] = bus_fp.split_pending;  assign d_spend[1] = bus_rr.split_pending;
   assign d_abusy[0] = bus_fp.arbiter_busy;   assign d_abusy[1] = bus_rr.arbiter_busy;
   assign d_bbusy[0] = bus_fp.bus_busy;       assign d_bbusy[1] = bus_rr.bus_busy;
   assign d_tout[0]  = bus_fp.timeout;        assign d_tout[1]  = bus_rr.timeout;
   assign d_owner[0] = bus_fp.owner;          assign d_owner[1] = bus_rr.owner;
   assign d_oslave[0] = bus_fp.owner_slave;   assign d_oslave[1] = bus_rr.owner_slave;

   // Behavioural model; index 0 = fixed priority, 1 = round robin.
   int m_phase [2];
   int m_owner [2];
   int m_oslave[2];
   int m_ptr   [2];
   int m_held  [2];   // BUSY cycles elapsed, counting the current one
   bit m_pend  [2][NM];
   int m_park  [2][NM];
   bit m_res   [2][NM];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset(int m);
      m_phase[m] = P_IDLE; m_owner[m] = 0; m_oslave[m] = 0; m_ptr[m] = 0; m_held[m] = 0;
      for (int i = 0; i < NM; i++) begin
         m_pend[m][i] = 0; m_park[m][i] = 0; m_res[m][i] = 0;
      end
   endfunction

   function automatic bit m_elig(int m, int i);
      if (!req[i] || m_pend[m][i] || sel_i[i] >= NS) return 0;
      for (int k = 0; k < NM; k++)
         if (k != i && m_pend[m][k] && m_park[m][k] == sel_i[i]) return 0;
      return 1;
   endfunction

   function automatic int m_pick(int m);
      for (int i = 0; i < NM; i++) if (m_res[m][i] && m_elig(m, i)) return i;
      for (int d = 0; d < NM; d++) begin
         int i = (m == 1) ? (m_ptr[m] + d) % NM : d;
         if (m_elig(m, i)) return i;
      end
      return -1;
   endfunction

   function automatic bit m_timeout(int m);
      return (m_phase[m] == P_BUSY) && !rst && !td && !sen[m_oslave[m]] &&
             req[m_owner[m]] && (m_held[m] == MAXC);
   endfunction

   function automatic void model_step(int m);
      bit rel [NM];
      bit any;
      int w;
      if (rst) begin model_reset(m); return; end
      for (int i = 0; i < NM; i++) rel[i] = m_pend[m][i] && !sen[m_park[m][i]];
      case (m_phase[m])
         P_IDLE: begin
            any = 0;
            for (int i = 0; i < NM; i++) any |= m_elig(m, i);
            if (any) m_phase[m] = P_ARB;
         end
         P_ARB: begin
            w = m_pick(m);
            if (w < 0) m_phase[m] = P_IDLE;
            else begin
               m_owner[m] = w; m_oslave[m] = sel_i[w]; m_res[m][w] = 0;
               m_held[m] = 1; m_phase[m] = P_BUSY;
            end
         end
         default: begin
            if (td) begin
               m_phase[m] = P_IDLE;
               if (m == 1) m_ptr[m] = (m_owner[m] + 1) % NM;
            end else if (sen[m_oslave[m]]) begin
               m_pend[m][m_owner[m]] = 1; m_park[m][m_owner[m]] = m_oslave[m];
               m_phase[m] = P_IDLE;
            end else if (!req[m_owner[m]] || m_held[m] == MAXC) begin
               m_phase[m] = P_IDLE;
            end else begin
               m_held[m]++;
            end
         end
      endcase
      for (int i = 0; i < NM; i++) if (rel[i]) begin m_pend[m][i] = 0; m_res[m][i] = 1; end
   endfunction

   // Inputs are set at a falling edge; this advances one clock and checks.
   task automatic cycle();
      logic [NM-1:0] eg, ep;
      #1;
      for (int m = 0; m < 2; m++) check_eq($sformatf("timeout[%0d]", m), d_tout[m], m_timeout(m));
      for (int m = 0; m < 2; m++) model_step(m);
      @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         eg = '0; ep = '0;
         if (m_phase[m] == P_BUSY) eg[m_owner[m]] = 1'b1;
         for (int i = 0; i < NM; i++) ep[i] = m_pend[m][i];
         check_eq($sformatf("grant[%0d]", m), d_grant[m], eg);
         check_eq($sformatf("onehot0[%0d]", m), $onehot0(d_grant[m]), 1);
         check_eq($sformatf("arbiter_busy[%0d]", m), d_abusy[m], m_phase[m] != P_IDLE);
         check_eq($sformatf("bus_busy[%0d]", m), d_bbusy[m], m_phase[m] == P_BUSY);
         check_eq($sformatf("owner[%0d]", m), d_owner[m], m_owner[m]);
         check_eq($sformatf("owner_slave[%0d]", m), d_oslave[m], m_oslave[m]);
         check_eq($sformatf("split_pending[%0d]", m), d_spend[m], ep);
      end
   endtask

   task automatic idle_inputs();
      req = '0; td = 1'b0; sen = '0;
      for (int i = 0; i < NM; i++) sel_i[i] = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset(0); model_reset(1);
      repeat (2) @(negedge clk);
      do_reset();
      check_eq("rst_grant", d_grant[0], 0);
      check_eq("rst_abusy", d_abusy[0], 0);

      // Two requesters: master 0 first, master 1 after trans_done.
      req = 4'b0011;
      cycle();
      check_eq("tp1_arb", d_abusy[0], 1);
      check_eq("tp1_nogrant", d_grant[0], 0);
      cycle();
      check_eq("tp1_grant0", d_grant[0], 4'b0001);
      repeat (3) cycle();
      td = 1'b1; req = 4'b0010;
      cycle();
      td = 1'b0;
      check_eq("tp1_release", d_grant[0], 0);
      repeat (2) cycle();
      check_eq("tp1_grant1", d_grant[0], 4'b0010);
      td = 1'b1; req = '0;
      cycle();
      td = 1'b0;

      // Split park and resume ahead of a competing request.
      do_reset();
      sel_i[0] = 1; sel_i[1] = 2; req = 4'b0001;
      repeat (2) cycle();
      sen = 3'b010; req = 4'b0011;
      cycle();
      check_eq("sp_park", d_spend[0], 4'b0001);
      repeat (2) cycle();
      check_eq("sp_other", d_grant[0], 4'b0010);
      td = 1'b1; sen = '0;
      cycle();
      td = 1'b0;
      check_eq("sp_clear", d_spend[0], 0);
      repeat (2) cycle();
      check_eq("sp_resume", d_grant[0], 4'b0001);
      check_eq("sp_resume_rr", d_grant[1], 4'b0001);

      // Slave conflict blocks master 1 while master 0 is parked.
      do_reset();
      sel_i[0] = 1; sel_i[1] = 1; req = 4'b0001;
      repeat (2) cycle();
      sen = 3'b010; req = 4'b0011;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check_eq("conflict_m1", d_grant[0][1], 0);
      end
      sen = '0;
      repeat (4) cycle();

      // Timeout on the tenth BUSY cycle.
      do_reset();
      req = 4'b0001;
      repeat (2) cycle();
      for (int k = 2; k <= 11; k++) begin
         #1;
         check_eq("tmo_pulse", d_tout[0], k == 11);
         cycle();
      end
      check_eq("tmo_release", d_grant[0], 0);
      req = '0;
      repeat (3) cycle();

      // trans_done together with the owner's split: no park.
      do_reset();
      sel_i[0] = 1; req = 4'b0001;
      repeat (2) cycle();
      td = 1'b1; sen = 3'b010;
      cycle();
      td = 1'b0;
      check_eq("done_split_nopark", d_spend[0], 0);
      sen = '0; req = '0;
      cycle();

      // Reset while BUSY with another master parked.
      do_reset();
      sel_i[1] = 2; req = 4'b0010;
      repeat (2) cycle();
      sen = 3'b100;
      cycle();
      req = 4'b0001;
      repeat (2) cycle();
      check_eq("rstbusy_pre", d_bbusy[0], 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("rstbusy_grant", d_grant[0], 0);
      check_eq("rstbusy_pend", d_spend[0], 0);
      check_eq("rstbusy_abusy", d_abusy[0], 0);
      check_eq("rstbusy_owner", d_owner[0], 0);
      check_eq("rstbusy_oslave", d_oslave[0], 0);

      // Out-of-range slave select never wins.
      do_reset();
      sel_i[0] = 3; req = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check_eq("bad_sel", d_abusy[0], 0);
      end

      // Randomised traffic.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         td  = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 15) == 0) sel_i[i] = $urandom_range(0, 3);
         end
         for (int j = 0; j < NS; j++)
            if ($urandom_range(0, 11) == 0) sen[j] = ~sen[j];
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_split.md
# bus_arbiter_split

Parametrised N-master bus arbiter with slave-select routing, split-transaction parking and a bus-hold timeout. It is the next-generation arbiter for the interconnect that joins the bridge and data-alter masters to the slave ports. It generalises the fixed two-master arbiter to NUM_MASTERS masters and NUM_SLAVES slaves, with selectable fixed-priority or round-robin policy. A slave asserting split releases the bus to other masters, and the parked master resumes with top priority.

## Interface
- NUM_MASTERS, 2, number of requesting masters (2..8)
- NUM_SLAVES, 3, number of slaves (≤ 2^SLAVE_LEN)
- SLAVE_LEN, 2, width of one slave-select field
- RR_MODE, 0, 0 = fixed priority (master 0 highest), 1 = round-robin
- MAX_COUNT, 500, bus-hold timeout in clk cycles (≥ 2)

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high
- request  in  NUM_MASTERS  per-master bus request, level
- slave_sel  in  NUM_MASTERS*SLAVE_LEN  target slave of master i at bits [i*SLAVE_LEN +: SLAVE_LEN]
- trans_done  in  1  owner's transaction complete, 1-cycle pulse
- split_en  in  NUM_SLAVES  slave j requests split, level
- grant  out  NUM_MASTERS  one-hot grant
- arbiter_busy  out  1  high in ARB and BUSY
- bus_busy  out  1  high in BUSY only
- owner  out  $clog2(NUM_MASTERS)  index of the granted or arbitrated master
- owner_slave  out  SLAVE_LEN  slave latched for the current owner
- split_pending  out  NUM_MASTERS  master i is parked on a split
- timeout  out  1  1-cycle pulse on forced release

## Operation
- States: IDLE, ARB, BUSY.
- Eligible requests: request[i] & ~split_pending[i].
  - Also masked: any master whose slave_sel equals the slave of another master's pending split.
  - Slave_sel ≥ NUM_SLAVES is ineligible and never granted.
- IDLE → ARB when any request is eligible.
- ARB: select the winner and latch owner and owner_slave.
  - Priority 1: resumed masters (split just cleared), lowest index first.
  - Priority 2, RR_MODE=0: lowest eligible index.
  - Priority 2, RR_MODE=1: first eligible index at or after rr_ptr, modulo NUM_MASTERS.
  - ARB → BUSY next cycle. grant[owner] is registered on entry to BUSY.
  - If the winner's request has dropped in ARB, go ARB → IDLE with no grant.
- BUSY exits, highest priority first; each goes to IDLE and clears grant:
  - reset.
  - trans_done: RR_MODE=1 sets rr_ptr ← (owner+1) mod NUM_MASTERS.
  - split_en[owner_slave] high: set split_pending[owner] and record the park slave.
  - request[owner] low (abort).
  - Timeout counter reaches MAX_COUNT-1: pulse timeout. No rr_ptr update.
- Split release:
  - split_pending[i] clears the cycle after split_en[park slave of i] is seen low.
  - Master i is flagged resumed until it is next granted.
- Timeout counter: clears on entry to BUSY and increments each BUSY cycle; width $clog2(MAX_COUNT+1).

## Timing
- Reset values:
  - grant=0, arbiter_busy=0, bus_busy=0, owner=0, owner_slave=0, split_pending=0, timeout=0.
  - rr_ptr=0, resumed flags 0, state IDLE.
- Latency: eligible request at cycle N → ARB at N+1 → grant and bus_busy at N+2.
- Release: trans_done, split, abort or timeout at cycle N → grant=0 at N+1, state IDLE.
  - Earliest next grant is N+3.
- Split resume: split_en falls at N → split_pending clears at N+1 → grant at N+3 if the bus is idle.
- Simultaneous trans_done and split_en[owner_slave]: trans_done wins; no park.
- A split_en from a non-owner slave during BUSY is ignored.
- grant is never asserted to two masters; it is zero outside BUSY.
- Reset mid-BUSY: all parks, pointers and counters clear on the next edge.

## Test plan
- NUM_MASTERS=2, RR_MODE=0:
  - request=2'b11 at cycle 0 → ARB at 1, grant=2'b01 and owner=0 at 2.
  - trans_done at 5 → grant=0 at 6; grant=2'b10 at 8.
- RR_MODE=1, NUM_MASTERS=4, all requesting, trans_done 3 cycles after each grant → grant order 0,1,2,3,0.
- Split sequence:
  - Master 0 owns slave 1; split_en[1] high → split_pending=2'b01, master 1 (slave 2) granted.
  - split_en[1] falls → master 0 granted next, ahead of a pending master 1 re-request.
- Conflict: master 0 parked on slave 1; master 1 requests slave 1 → master 1 is never granted until the split clears.
- MAX_COUNT=10, no trans_done → timeout pulse in the 10th BUSY cycle, grant=0 on the next edge.
- Boundaries:
  - trans_done with split_en → no park.
  - reset during BUSY → all outputs return to their reset values one cycle later.
  - slave_sel=3 with NUM_SLAVES=3 → never granted.
